// File: rtl/spike_volley_encoder.sv
// rtl/spike_volley_encoder.sv - time-to-first-spike volley encoder for one gamma period
`ifndef LOG_TIME_PERIOD
`define LOG_TIME_PERIOD 3
`endif

module spike_volley_encoder #(
  parameter int N_INPUTS = 16,
  parameter int TW       = `LOG_TIME_PERIOD,
  parameter int CW       = $clog2(N_INPUTS) + 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [N_INPUTS-1:0]    spike_mask,
  input  logic [N_INPUTS*TW-1:0] spike_times,
  output logic                   busy,
  output logic                   volley_valid,
  output logic [TW:0]            time_val,
  output logic [N_INPUTS-1:0]    spike_volley,
  output logic                   gamma_done,
  output logic [CW-1:0]          spike_count
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [TW-1:0] T_LAST = {TW{1'b1}};
  localparam logic [TW:0]   T_VAL  = {1'b1, {TW{1'b0}}};

  state_t                   state_q, state_d;
  logic [TW-1:0]            t_q, t_d;
  logic [N_INPUTS-1:0]      mask_q, mask_d;
  logic [N_INPUTS*TW-1:0]   times_q, times_d;
  logic [CW-1:0]            acc_q, acc_d;
  logic                     busy_q, busy_d;
  logic                     volley_valid_q, volley_valid_d;
  logic [TW:0]              time_val_q, time_val_d;
  logic [N_INPUTS-1:0]      spike_volley_q, spike_volley_d;
  logic                     gamma_done_q, gamma_done_d;
  logic [CW-1:0]            spike_count_q, spike_count_d;
  logic [N_INPUTS-1:0]      volley_next;
  logic [TW-1:0]            t_next;

  // Inputs whose time equals slot t fire in that slot.
  function automatic logic [N_INPUTS-1:0] volley_at(
    input logic [N_INPUTS-1:0]    m,
    input logic [N_INPUTS*TW-1:0] ts,
    input logic [TW-1:0]          t
  );
    logic [N_INPUTS-1:0] v;
    v = '0;
    for (int i = 0; i < N_INPUTS; i++) begin
      v[i] = m[i] && (ts[i*TW +: TW] == t);
    end
    return v;
  endfunction

  function automatic logic [CW-1:0] popcount(input logic [N_INPUTS-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < N_INPUTS; i++) begin
      c = c + CW'(v[i]);
    end
    return c;
  endfunction

  // Next-state and registered-output computation; the slot-0 volley is formed
  // from the live inputs on the accepting edge so it appears one cycle after start.
  always_comb begin
    state_d        = state_q;
    t_d            = t_q;
    mask_d         = mask_q;
    times_d        = times_q;
    acc_d          = acc_q;
    busy_d         = 1'b0;
    volley_valid_d = 1'b0;
    time_val_d     = '0;
    spike_volley_d = '0;
    gamma_done_d   = 1'b0;
    spike_count_d  = spike_count_q;
    volley_next    = '0;
    t_next         = t_q + TW'(1);

    case (state_q)
      RUN: begin
        busy_d = 1'b1;
        if (t_q == T_LAST) begin
          state_d       = DONE;
          gamma_done_d  = 1'b1;
          time_val_d    = T_VAL;
          spike_count_d = acc_q;
        end else begin
          volley_next    = volley_at(mask_q, times_q, t_next);
          t_d            = t_next;
          spike_volley_d = volley_next;
          volley_valid_d = 1'b1;
          time_val_d     = {1'b0, t_next};
          acc_d          = acc_q + popcount(volley_next);
        end
      end
      default: begin
        // IDLE and DONE both accept a new period; otherwise DONE drops to IDLE.
        if (start) begin
          volley_next    = volley_at(spike_mask, spike_times, '0);
          state_d        = RUN;
          mask_d         = spike_mask;
          times_d        = spike_times;
          t_d            = '0;
          acc_d          = popcount(volley_next);
          busy_d         = 1'b1;
          volley_valid_d = 1'b1;
          time_val_d     = '0;
          spike_volley_d = volley_next;
          spike_count_d  = '0;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      t_q            <= '0;
      mask_q         <= '0;
      times_q        <= '0;
      acc_q          <= '0;
      busy_q         <= 1'b0;
      volley_valid_q <= 1'b0;
      time_val_q     <= '0;
      spike_volley_q <= '0;
      gamma_done_q   <= 1'b0;
      spike_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      t_q            <= t_d;
      mask_q         <= mask_d;
      times_q        <= times_d;
      acc_q          <= acc_d;
      busy_q         <= busy_d;
      volley_valid_q <= volley_valid_d;
      time_val_q     <= time_val_d;
      spike_volley_q <= spike_volley_d;
      gamma_done_q   <= gamma_done_d;
      spike_count_q  <= spike_count_d;
    end
  end

  assign busy         = busy_q;
  assign volley_valid = volley_valid_q;
  assign time_val     = time_val_q;
  assign spike_volley = spike_volley_q;
  assign gamma_done   = gamma_done_q;
  assign spike_count  = spike_count_q;

endmodule
